eth_std_main_system_cpu_cpu_mul_combine: RTL

Consumes the three registered 16x16 partial products of the CPU multiply cell in the M stage and folds them into the 32-bit product delivered to the W stage. Two-stage pipeline: register partials, add middle terms, align and add. Optionally computes the high word (`mulxuu`) with a 16-cycle shift-add sequencer that stalls the core while busy.

---
 rtl/eth_std_main_system_cpu_cpu_mul_combine.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/eth_std_main_system_cpu_cpu_mul_combine.sv
// eth_std_main_system_cpu_cpu_mul_combine
//
// Folds the three 16x16 partial products of the CPU multiply cell (M stage)
// into the 32-bit product delivered to the W stage.
//   Stage A : register a_lo*b_lo, add the two middle terms (33-bit, carry kept)
//   Stage B : align the middle sum by 16 and add it to a_lo*b_lo -> low word
//
// Optional high-word path: define ETH_STD_MAIN_SYSTEM_CPU_MULX_EN to build a
// 16-cycle shift-add sequencer (IDLE -> ITER -> FINAL -> IDLE) that computes
// the upper 32 bits of the 64-bit product for mulxuu and stalls the core
// while it runs. Without the macro every start yields the low word and
// W_mul_stall is tied low.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   M_en                    M-stage advance; low freezes the low-word pipeline
//   M_mul_start             partials belong to a multiply (sampled when M_en)
//   M_op_mulx               with M_mul_start: request the high word
//   M_mul_cell_p1/p2/p3     a_lo*b_lo, a_lo*b_hi, a_hi*b_lo
//   M_src1_hi, M_src2_hi    a_hi, b_hi, aligned with the partials
//   W_mul_result            low word, or high word for a mulx
//   W_mul_valid             one-cycle strobe qualifying W_mul_result
//   W_mul_stall             sequencer busy
//   dbg_state               sequencer state (0 = IDLE, 1 = ITER, 2 = FINAL)
//
// Handshake: a multiply is accepted on a rising edge where M_en, M_mul_start
// and !W_mul_stall are all 1; starts seen while W_mul_stall is 1 are dropped.
// The result is presented for exactly one cycle with W_mul_valid=1; there is
// no back-pressure on the W side.
module eth_std_main_system_cpu_cpu_mul_combine #(
  parameter int MUL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 M_en,
  input  logic                 M_mul_start,
  input  logic                 M_op_mulx,
  input  logic [2*MUL_W-1:0]   M_mul_cell_p1,
  input  logic [2*MUL_W-1:0]   M_mul_cell_p2,
  input  logic [2*MUL_W-1:0]   M_mul_cell_p3,
  input  logic [MUL_W-1:0]     M_src1_hi,
  input  logic [MUL_W-1:0]     M_src2_hi,
  output logic [2*MUL_W-1:0]   W_mul_result,
  output logic                 W_mul_valid,
  output logic                 W_mul_stall,
  output logic [1:0]           dbg_state
);

  localparam int PW = 2 * MUL_W;
  localparam int CW = $clog2(MUL_W);

  // Middle terms summed with the carry kept (bit PW).
  logic [PW:0] mid_in;
  assign mid_in = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};

  logic start_ok;   // start accepted this edge (gated by M_en and stall)
  logic mulx_req;   // accepted start that asks for the high word
  logic fin;        // sequencer presenting the high word this cycle
  logic [PW-1:0] high;

  // ---------------------------------------------------------------- stage A
  logic [PW-1:0] a_p1;
  logic [PW:0]   a_mid;
  logic          a_vld;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_p1  <= '0;
      a_mid <= '0;
      a_vld <= 1'b0;
    end else if (M_en) begin
      if (start_ok) begin
        a_p1  <= M_mul_cell_p1;
        a_mid <= mid_in;
        // A mulx is answered by the sequencer, never by the low-word path.
        a_vld <= ~mulx_req;
      end else begin
        a_vld <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- stage B
  logic [PW:0]   lo_sum;
  logic [PW-1:0] w_res;
  logic          w_vld;

  assign lo_sum = {1'b0, a_p1} + {1'b0, a_mid[MUL_W-1:0], {MUL_W{1'b0}}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_res <= '0;
      w_vld <= 1'b0;
    end else if (M_en) begin
      w_res <= lo_sum[PW-1:0];
      w_vld <= a_vld;
    end else begin
      // The result holds, but the strobe drops so a frozen stage never
      // reports the same product twice; a_vld re-arms it once M_en returns.
      w_vld <= 1'b0;
    end
  end

`ifdef ETH_STD_MAIN_SYSTEM_CPU_MULX_EN
  // ------------------------------------------------------ high-word sequencer
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ITER  = 2'd1,
    S_FINAL = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [MUL_W-1:0] mx_a;
  logic [MUL_W-1:0] mx_b;
  logic [MUL_W:0]   mx_mid_hi;  // mid[32:16]
  logic             mx_c;       // carry out of the low-word sum
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [PW:0]      in_lo;

  // The core freezes M_en during the stall, so stage B would never see the
  // mulx operands; the low-word carry is therefore taken from the inputs.
  assign in_lo = {1'b0, M_mul_cell_p1} + {1'b0, mid_in[MUL_W-1:0], {MUL_W{1'b0}}};

  assign start_ok = M_en & M_mul_start & (state == S_IDLE);
  assign mulx_req = start_ok & M_op_mulx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (mulx_req) state_nxt = S_ITER;
      S_ITER:  if (cnt == CW'(MUL_W - 1)) state_nxt = S_FINAL;
      S_FINAL: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mx_a      <= '0;
      mx_b      <= '0;
      mx_mid_hi <= '0;
      mx_c      <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
    end else if (mulx_req) begin
      mx_a      <= M_src1_hi;
      mx_b      <= M_src2_hi;
      mx_mid_hi <= mid_in[PW:MUL_W];
      mx_c      <= in_lo[PW];
      acc       <= '0;
      cnt       <= '0;
    end else if (state == S_ITER) begin
      if (mx_b[cnt]) acc <= acc + ({{MUL_W{1'b0}}, mx_a} << cnt);
      cnt <= cnt + CW'(1);
    end
  end

  assign high = acc + {{(PW-MUL_W-1){1'b0}}, mx_mid_hi} + {{(PW-1){1'b0}}, mx_c};
  assign fin         = (state == S_FINAL);
  assign W_mul_stall = (state != S_IDLE);
  assign dbg_state   = state;

  logic unused_mulx;
  assign unused_mulx = ^in_lo[PW-1:0];
`else
  assign start_ok    = M_en & M_mul_start;
  assign mulx_req    = 1'b0;
  assign fin         = 1'b0;
  assign high        = '0;
  assign W_mul_stall = 1'b0;
  assign dbg_state   = 2'd0;

  logic unused_cfg;
  assign unused_cfg = ^{M_op_mulx, M_src1_hi, M_src2_hi};
`endif

  // Upper mid bits and the low-word carry only matter to the sequencer,
  // which derives them from its own captured operands.
  logic unused_common;
  assign unused_common = ^{a_mid[PW:MUL_W], lo_sum[PW]};

  // ---------------------------------------------------------------- outputs
  // FINAL never coincides with a low-word strobe: no low-word op can be
  // accepted while the sequencer is busy.
  assign W_mul_result = fin ? high : w_res;
  assign W_mul_valid  = w_vld | fin;

endmodule
